// File: rtl/sdp_pipe.sv
// Simple dual-port RAM with byte-enabled writes and a credit-controlled read pipeline.
// Read results flow through a small output FIFO so rd_data backpressure never loses data.
module sdp_pipe #(
    parameter int unsigned W_DATA   = 16,
    parameter int unsigned W_ADDR   = 16,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned WR_FIRST = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wr_addr_data_valid,
    output logic                                wr_addr_data_ready,
    input  logic [W_ADDR+W_DATA+W_DATA/8-1:0]   wr_addr_data_data,
    input  logic                                rd_addr_valid,
    output logic                                rd_addr_ready,
    input  logic [W_ADDR-1:0]                   rd_addr_data,
    output logic                                rd_data_valid,
    input  logic                                rd_data_ready,
    output logic [W_DATA-1:0]                   rd_data_data
);

    localparam int unsigned NB        = W_DATA / 8;
    localparam int unsigned IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FifoDepth = RD_LAT + 1;
    localparam int unsigned PtrW      = $clog2(FifoDepth);
    localparam int unsigned CntW      = $clog2(FifoDepth + 1);

    localparam logic [W_ADDR:0]  DepthLim = (W_ADDR + 1)'(DEPTH);
    localparam logic [CntW:0]    Credits  = (CntW + 1)'(RD_LAT + 1);
    localparam logic [PtrW-1:0]  PtrLast  = PtrW'(FifoDepth - 1);

    logic [W_DATA-1:0] mem [DEPTH];

    logic [W_ADDR-1:0] wr_addr;
    logic [W_DATA-1:0] wr_wdata;
    logic [NB-1:0]     wr_be;
    logic              wr_fire;
    logic              wr_in_range;

    logic              rd_in_range;
    logic              rd_accept;
    logic [W_DATA-1:0] rd_old;
    logic [W_DATA-1:0] rd_word;

    logic              pipe_v_q [RD_LAT];
    logic [W_DATA-1:0] pipe_d_q [RD_LAT];

    logic [W_DATA-1:0] fifo_q [FifoDepth];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]   cnt_q;

    logic              fifo_empty;
    logic              arrive;
    logic [W_DATA-1:0] arrive_d;
    logic              pop;
    logic              fifo_push;
    logic              fifo_pop;
    logic [CntW:0]     in_flight;
    logic [CntW:0]     outstanding;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    assign wr_addr  = wr_addr_data_data[W_ADDR-1:0];
    assign wr_wdata = wr_addr_data_data[W_ADDR +: W_DATA];
    assign wr_be    = wr_addr_data_data[W_ADDR+W_DATA +: NB];

    assign wr_addr_data_ready = rst;
    assign wr_fire            = wr_addr_data_valid && wr_addr_data_ready;
    assign wr_in_range        = {1'b0, wr_addr} < DepthLim;

    always_ff @(posedge clk) begin
        if (wr_fire && wr_in_range) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_be[k]) mem[wr_addr[IdxW-1:0]][8*k +: 8] <= wr_wdata[8*k +: 8];
            end
        end
    end

    assign rd_in_range = {1'b0, rd_addr_data} < DepthLim;
    assign rd_old      = mem[rd_addr_data[IdxW-1:0]];

    // Same-cycle collision: optionally forward the bytes being written this edge.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = rd_old;
            if (WR_FIRST != 0 && wr_fire && wr_in_range && wr_addr == rd_addr_data) begin
                for (int k = 0; k < NB; k++) begin
                    if (wr_be[k]) rd_word[8*k +: 8] = wr_wdata[8*k +: 8];
                end
            end
        end
    end

    assign arrive        = pipe_v_q[RD_LAT-1];
    assign arrive_d      = pipe_d_q[RD_LAT-1];
    assign fifo_empty    = (cnt_q == '0);
    assign rd_data_valid = !fifo_empty || arrive;
    assign rd_data_data  = fifo_empty ? arrive_d : fifo_q[rd_ptr_q];
    assign pop           = rd_data_valid && rd_data_ready;
    // An arriving word bypasses the FIFO when it is empty and the consumer takes it now.
    assign fifo_push     = arrive && !(fifo_empty && rd_data_ready);
    assign fifo_pop      = pop && !fifo_empty;

    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight = in_flight + (CntW + 1)'(pipe_v_q[i]);
        end
        outstanding = in_flight + (CntW + 1)'(cnt_q) - (CntW + 1)'(pop);
    end

    assign rd_addr_ready = rst && (outstanding < Credits);
    assign rd_accept     = rd_addr_valid && rd_addr_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) pipe_v_q[i] <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            pipe_v_q[0] <= rd_accept;
            for (int i = 1; i < RD_LAT; i++) pipe_v_q[i] <= pipe_v_q[i-1];
            if (fifo_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (fifo_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_q + CntW'(fifo_push) - CntW'(fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        pipe_d_q[0] <= rd_word;
        for (int i = 1; i < RD_LAT; i++) pipe_d_q[i] <= pipe_d_q[i-1];
        if (fifo_push) fifo_q[wr_ptr_q] <= arrive_d;
    end

endmodule

// File: tb/tb_sdp_pipe.sv
// Bench for sdp_pipe: two instances (RD_LAT=1/WR_FIRST=1 and RD_LAT=2/WR_FIRST=0) share
// stimulus and are checked each cycle against a queue-based transaction model.
module tb_sdp_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wv, rav, rdr;
    logic [33:0] wpk;
    logic [15:0] ra;
    logic        wrdy [2];
    logic        rrdy [2];
    logic        rv   [2];
    logic [15:0] rdat [2];

    sdp_pipe #(.W_DATA(16), .W_ADDR(16), .DEPTH(1024), .RD_LAT(1), .WR_FIRST(1)) dut_a (
        .clk(clk), .rst(rst),
        .wr_addr_data_valid(wv), .wr_addr_data_ready(wrdy[0]), .wr_addr_data_data(wpk),
        .rd_addr_valid(rav), .rd_addr_ready(rrdy[0]), .rd_addr_data(ra),
        .rd_data_valid(rv[0]), .rd_data_ready(rdr), .rd_data_data(rdat[0])
    );

    sdp_pipe #(.W_DATA(16), .W_ADDR(16), .DEPTH(1024), .RD_LAT(2), .WR_FIRST(0)) dut_b (
        .clk(clk), .rst(rst),
        .wr_addr_data_valid(wv), .wr_addr_data_ready(wrdy[1]), .wr_addr_data_data(wpk),
        .rd_addr_valid(rav), .rd_addr_ready(rrdy[1]), .rd_addr_data(ra),
        .rd_data_valid(rv[1]), .rd_data_ready(rdr), .rd_data_data(rdat[1])
    );

    typedef struct {
        logic [15:0] data;
        int          due;
    } ent_t;

    typedef struct {
        logic        w;
        logic [15:0] wa;
        logic [15:0] wd;
        logic [1:0]  be;
        logic        a;
        logic [15:0] raddr;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    logic [15:0] mm [1024];
    ent_t        sb [2][16];
    int          hd [2];
    int          tl [2];
    int          cyc;
    int          nvec;
    int          nfail;
    logic        dv [2];
    logic [15:0] dd [2];
    logic        sr [2];
    logic        seen [2];
    vec_t        tbl [12];
    int          cnt [2];

    task automatic chk(input string nm, input int inst, input logic [15:0] act,
                       input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s[%0d]: got %h, expected %h (cycle %0d)", nm, inst, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] w,
                                          input logic [1:0] b);
        logic [15:0] m;
        m = o;
        if (b[0]) m[7:0]  = w[7:0];
        if (b[1]) m[15:8] = w[15:8];
        return m;
    endfunction

    // One clock cycle: drive, check outputs against the model, then advance the model.
    task automatic step(input logic r, input logic w, input logic [15:0] wa,
                        input logic [15:0] wd, input logic [1:0] be, input logic a,
                        input logic [15:0] raddr, input logic dr);
        int          lat, sz;
        logic        ev, pp, er, inr;
        logic [15:0] val;
        ent_t        ent;
        @(negedge clk);
        rst = r; wv = w; wpk = {be, wd, wa}; rav = a; ra = raddr; rdr = dr;
        #1;
        inr = int'(raddr) < 1024;
        val = inr ? mm[raddr[9:0]] : 16'h0;
        for (int i = 0; i < 2; i++) begin
            lat = i + 1;
            sz  = tl[i] - hd[i];
            ev  = r && sz > 0 && sb[i][hd[i] % 16].due <= cyc;
            pp  = ev && dr;
            er  = r && (sz - int'(pp) < lat + 1);
            chk("wr_ready", i, 16'(wrdy[i]), 16'(r));
            chk("rd_addr_ready", i, 16'(rrdy[i]), 16'(er));
            chk("rd_data_valid", i, 16'(rv[i]), 16'(ev));
            if (ev) chk("rd_data", i, rdat[i], sb[i][hd[i] % 16].data);
            dv[i] = rv[i];
            dd[i] = rdat[i];
            sr[i] = rrdy[i];
            if (!r) begin
                hd[i] = 0;
                tl[i] = 0;
            end else begin
                if (pp) hd[i]++;
                if (a && er) begin
                    ent.data = val;
                    if (inr && w && wa == raddr && i == 0) ent.data = merge(val, wd, be);
                    ent.due = cyc + lat;
                    sb[i][tl[i] % 16] = ent;
                    tl[i]++;
                end
            end
        end
        if (r && w && int'(wa) < 1024) mm[wa[9:0]] = merge(mm[wa[9:0]], wd, be);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 16'h0, 1'b1);
    endtask

    initial begin
        nvec = 0; nfail = 0; cyc = 0;
        hd = '{0, 0}; tl = '{0, 0};
        rst = 1'b0; wv = 1'b0; wpk = '0; rav = 1'b0; ra = '0; rdr = 1'b0;

        tbl[0]  = '{1'b1, 16'd5,    16'hBEEF, 2'b11, 1'b0, 16'd0,    16'h0,    16'h0};
        tbl[1]  = '{1'b0, 16'd0,    16'h0,    2'b00, 1'b1, 16'd5,    16'hBEEF, 16'hBEEF};
        tbl[2]  = '{1'b1, 16'd7,    16'h1234, 2'b11, 1'b0, 16'd0,    16'h0,    16'h0};
        tbl[3]  = '{1'b1, 16'd7,    16'hABCD, 2'b01, 1'b0, 16'd0,    16'h0,    16'h0};
        tbl[4]  = '{1'b0, 16'd0,    16'h0,    2'b00, 1'b1, 16'd7,    16'h12CD, 16'h12CD};
        tbl[5]  = '{1'b1, 16'd3,    16'h0000, 2'b11, 1'b0, 16'd0,    16'h0,    16'h0};
        tbl[6]  = '{1'b1, 16'd3,    16'h5A5A, 2'b10, 1'b1, 16'd3,    16'h5A00, 16'h0000};
        tbl[7]  = '{1'b0, 16'd0,    16'h0,    2'b00, 1'b1, 16'd3,    16'h5A00, 16'h5A00};
        tbl[8]  = '{1'b1, 16'd0,    16'h1111, 2'b11, 1'b0, 16'd0,    16'h0,    16'h0};
        tbl[9]  = '{1'b1, 16'd1024, 16'hFFFF, 2'b11, 1'b0, 16'd0,    16'h0,    16'h0};
        tbl[10] = '{1'b0, 16'd0,    16'h0,    2'b00, 1'b1, 16'd1024, 16'h0000, 16'h0000};
        tbl[11] = '{1'b0, 16'd0,    16'h0,    2'b00, 1'b1, 16'd0,    16'h1111, 16'h1111};

        step(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b1, 16'h0, 16'h0, 2'b11, 1'b1, 16'h0, 1'b1);

        // Give every word a known value so later reads have a defined expectation.
        for (int ad = 0; ad < 1024; ad++)
            step(1'b1, 1'b1, 16'(ad), 16'($urandom), 2'b11, 1'b0, 16'h0, 1'b1);

        for (int n = 0; n < 12; n++) begin
            step(1'b1, tbl[n].w, tbl[n].wa, tbl[n].wd, tbl[n].be, tbl[n].a, tbl[n].raddr, 1'b1);
            if (tbl[n].a) begin
                seen = '{1'b0, 1'b0};
                for (int k = 0; k < 5; k++) begin
                    idle(1);
                    for (int i = 0; i < 2; i++) begin
                        if (!seen[i] && dv[i]) begin
                            seen[i] = 1'b1;
                            chk($sformatf("table_row%0d", n), i, dd[i],
                                (i == 0) ? tbl[n].exp_a : tbl[n].exp_b);
                        end
                    end
                end
                for (int i = 0; i < 2; i++) chk("table_result_seen", i, 16'(seen[i]), 16'd1);
            end
        end

        // Backpressure: credits cap acceptance at RD_LAT+1, then full throughput on release.
        cnt = '{0, 0};
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'($urandom_range(0, 1023)), 1'b0);
            for (int i = 0; i < 2; i++) cnt[i] += int'(sr[i]);
        end
        chk("bp_accepts", 0, 16'(cnt[0]), 16'd2);
        chk("bp_accepts", 1, 16'(cnt[1]), 16'd3);
        cnt = '{0, 0};
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'($urandom_range(0, 1023)), 1'b1);
            for (int i = 0; i < 2; i++) cnt[i] += int'(sr[i]);
        end
        chk("bp_resume_accepts", 0, 16'(cnt[0]), 16'd8);
        chk("bp_resume_accepts", 1, 16'(cnt[1]), 16'd8);
        idle(5);

        // Reset with reads in flight and buffered.
        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'(k + 40), 1'b0);
        step(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 2; i++) chk("rst_valid_low", i, 16'(dv[i]), 16'd0);
        step(1'b0, 1'b1, 16'd40, 16'hDEAD, 2'b11, 1'b1, 16'd40, 1'b1);
        for (int k = 0; k < 4; k++) begin
            idle(1);
            for (int i = 0; i < 2; i++) chk("post_rst_no_stale", i, 16'(dv[i]), 16'd0);
        end
        step(1'b1, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'd41, 1'b1);
        idle(4);

        // Random traffic with frequent same-address collisions and out-of-range addresses.
        for (int k = 0; k < 800; k++) begin
            logic [15:0] wa_r;
            wa_r = 16'($urandom_range(0, 1099));
            step(1'b1, 1'($urandom % 2), wa_r, 16'($urandom), 2'($urandom), ($urandom % 10) < 6,
                 (($urandom % 4) == 0) ? wa_r : 16'($urandom_range(0, 1099)),
                 ($urandom % 10) < 7);
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
